// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-to-writeback handshake and payload bundle
interface wb_stage_if #(
    parameter int XLEN = 64
);
    logic            i_mem_valid;
    logic            o_mem_ready;
    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_inst;
    logic [4:0]      i_rd;
    logic            i_rd_wen;
    logic            i_is_load;
    logic [2:0]      i_funct3;
    logic [2:0]      i_addr_off;
    logic [XLEN-1:0] i_alu_data;
    logic [XLEN-1:0] i_load_data;

    modport master (
        output i_mem_valid, i_pc, i_inst, i_rd, i_rd_wen, i_is_load,
               i_funct3, i_addr_off, i_alu_data, i_load_data,
        input  o_mem_ready
    );

    modport slave (
        input  i_mem_valid, i_pc, i_inst, i_rd, i_rd_wen, i_is_load,
               i_funct3, i_addr_off, i_alu_data, i_load_data,
        output o_mem_ready
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV64 writeback stage: load extraction, result register, commit record, counters, trap halt
module wb_stage #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] TRAP_INST = 32'h0000_006b
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_if.slave       mem,
    input  logic            i_hold,
    output logic [4:0]      o_rd,
    output logic            o_rd_wen,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_commit_valid,
    output logic [XLEN-1:0] o_commit_pc,
    output logic [31:0]     o_commit_inst,
    output logic [63:0]     o_cycle_cnt,
    output logic [63:0]     o_instret_cnt,
    output logic            o_halt
);
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [4:0]      r_rd;
    logic            r_rd_wen;
    logic [XLEN-1:0] r_data;
    logic            r_halt;
    logic [63:0]     r_cycle_cnt;
    logic [63:0]     r_instret_cnt;

    logic            w_fire;
    logic            w_retire;
    logic            w_trap_retire;
    logic [2:0]      w_masked_off;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_capture_data;

    assign mem.o_mem_ready = !r_halt && (!r_valid || !i_hold);
    assign w_fire          = mem.i_mem_valid && mem.o_mem_ready;
    assign w_retire        = r_valid && !i_hold;
    assign w_trap_retire   = w_retire && (r_inst == TRAP_INST);

    // Clear the low offset bits below the access size so the shift lands on the naturally aligned lane.
    always_comb begin
        w_masked_off = 3'd0;
        case (mem.i_funct3[1:0])
            2'b00:   w_masked_off = mem.i_addr_off;
            2'b01:   w_masked_off = {mem.i_addr_off[2:1], 1'b0};
            2'b10:   w_masked_off = {mem.i_addr_off[2], 2'b00};
            default: w_masked_off = 3'd0;
        endcase
    end

    assign w_shifted = mem.i_load_data >> {w_masked_off, 3'b000};

    always_comb begin
        w_load_val = '0;
        case (mem.i_funct3)
            3'b000:  w_load_val = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_val = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_val = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load_val = w_shifted;
            3'b100:  w_load_val = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load_val = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: w_load_val = '0;
        endcase
    end

    assign w_capture_data = mem.i_is_load ? w_load_val : mem.i_alu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_inst        <= '0;
            r_rd          <= '0;
            r_rd_wen      <= 1'b0;
            r_data        <= '0;
            r_halt        <= 1'b0;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
            if (w_trap_retire) begin
                r_halt <= 1'b1;
            end
            // Anything accepted on the edge the trap retires lies past the trap and is discarded.
            if (w_fire && !w_trap_retire) begin
                r_valid  <= 1'b1;
                r_pc     <= mem.i_pc;
                r_inst   <= mem.i_inst;
                r_rd     <= mem.i_rd;
                r_rd_wen <= mem.i_rd_wen && (mem.i_rd != 5'd0);
                r_data   <= w_capture_data;
            end else if (w_retire) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign o_rd           = r_rd;
    assign o_rd_data      = r_data;
    assign o_rd_wen       = w_retire && r_rd_wen;
    assign o_commit_valid = w_retire;
    assign o_commit_pc    = r_pc;
    assign o_commit_inst  = r_inst;
    assign o_cycle_cnt    = r_cycle_cnt;
    assign o_instret_cnt  = r_instret_cnt;
    assign o_halt         = r_halt;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a behavioural load/commit model
module tb_wb_stage;
    localparam logic [31:0] TRAP = 32'h0000_006b;

    logic        clk;
    logic        rst;
    logic        i_hold;
    logic [4:0]  o_rd;
    logic        o_rd_wen;
    logic [63:0] o_rd_data;
    logic        o_commit_valid;
    logic [63:0] o_commit_pc;
    logic [31:0] o_commit_inst;
    logic [63:0] o_cycle_cnt;
    logic [63:0] o_instret_cnt;
    logic        o_halt;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_instret;
    logic [63:0] tb_edges;

    wb_stage_if #(.XLEN(64)) mem_if ();

    wb_stage #(.XLEN(64), .TRAP_INST(TRAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem            (mem_if),
        .i_hold         (i_hold),
        .o_rd           (o_rd),
        .o_rd_wen       (o_rd_wen),
        .o_rd_data      (o_rd_data),
        .o_commit_valid (o_commit_valid),
        .o_commit_pc    (o_commit_pc),
        .o_commit_inst  (o_commit_inst),
        .o_cycle_cnt    (o_cycle_cnt),
        .o_instret_cnt  (o_instret_cnt),
        .o_halt         (o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_edges <= 64'd0;
        else     tb_edges <= tb_edges + 64'd1;
    end

    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] f3, input logic [2:0] off);
        int          size;
        int          aoff;
        logic [63:0] mask;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        aoff = (int'(off) / size) * size;
        mask = (size == 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
        v    = (d >> (8 * aoff)) & mask;
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                         input logic wen, input logic ld, input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] alu, input logic [63:0] ldd);
        mem_if.i_mem_valid = v;
        mem_if.i_pc        = pc;
        mem_if.i_inst      = inst;
        mem_if.i_rd        = rd;
        mem_if.i_rd_wen    = wen;
        mem_if.i_is_load   = ld;
        mem_if.i_funct3    = f3;
        mem_if.i_addr_off  = off;
        mem_if.i_alu_data  = alu;
        mem_if.i_load_data = ldd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_hold = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 64'd0;
        #1;
        n_vec++; if (o_commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit got %b exp 0", o_commit_valid); end
        n_vec++; if (o_rd_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", o_rd_wen); end
        n_vec++; if (o_rd_data !== 64'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", o_rd_data); end
        n_vec++; if (o_cycle_cnt !== 64'd0) begin n_err++; $display("FAIL reset_cycle got %0d exp 0", o_cycle_cnt); end
        n_vec++; if (o_instret_cnt !== 64'd0) begin n_err++; $display("FAIL reset_instret got %0d exp 0", o_instret_cnt); end
        n_vec++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b exp 0", o_halt); end
        n_vec++; if (mem_if.o_mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", mem_if.o_mem_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 64'h1000 + 64'(4*i), 32'h0000_0013, 5'(i), 1, 0, 0, 0, 64'(8'h11 * i), 0);
            tick();
            exp_instret++;
            n_vec++; if (o_rd_wen !== 1'b1) begin n_err++; $display("FAIL b2b_wen[%0d] got %b exp 1", i, o_rd_wen); end
            n_vec++; if (o_rd !== 5'(i)) begin n_err++; $display("FAIL b2b_rd[%0d] got %0d exp %0d", i, o_rd, i); end
            n_vec++; if (o_rd_data !== 64'(8'h11 * i)) begin n_err++; $display("FAIL b2b_data[%0d] got %h exp %h", i, o_rd_data, 8'h11 * i); end
            n_vec++; if (mem_if.o_mem_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, mem_if.o_mem_ready); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_vec++; if (o_commit_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", o_commit_valid); end
        n_vec++; if (o_instret_cnt !== 64'd4) begin n_err++; $display("FAIL b2b_instret got %0d exp 4", o_instret_cnt); end
        n_vec++; if (o_cycle_cnt !== tb_edges) begin n_err++; $display("FAIL b2b_cycle got %0d exp %0d", o_cycle_cnt, tb_edges); end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b011, 3'b111};
        logic [2:0]  offs [7] = '{3'd7, 3'd7, 3'd3, 3'd4, 3'd4, 3'd5, 3'd1};
        logic [63:0] exps [7] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433, 64'hFFFF_FFFF_8877_6655,
                                  64'h8877_6655, 64'h8877_6655_4433_2211, 64'h0};
        for (int i = 0; i < 7; i++) begin
            drive(1, 64'h2000 + 64'(i), 32'h0000_0003, 5'd10, 1, 1, f3s[i], offs[i], 64'hAAAA, 64'h8877_6655_4433_2211);
            tick();
            exp_instret++;
            n_vec++; if (o_rd_data !== exps[i]) begin n_err++; $display("FAIL load_dir[%0d] got %h exp %h", i, o_rd_data, exps[i]); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        logic [63:0] pc, alu, ldd, exp_data;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen, ld;
        logic [2:0]  f3, off;
        for (int i = 0; i < 60; i++) begin
            pc   = {$urandom, $urandom};
            inst = $urandom;
            if (inst == TRAP) inst = inst ^ 32'h100;
            rd   = 5'($urandom_range(0, 31));
            wen  = 1'($urandom);
            ld   = 1'($urandom);
            f3   = 3'($urandom);
            off  = 3'($urandom);
            alu  = {$urandom, $urandom};
            ldd  = {$urandom, $urandom};
            exp_data = ld ? ref_load(ldd, f3, off) : alu;
            drive(1, pc, inst, rd, wen, ld, f3, off, alu, ldd);
            tick();
            exp_instret++;
            n_vec++; if (o_rd_data !== exp_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h f3=%0d off=%0d", i, o_rd_data, exp_data, f3, off); end
            n_vec++; if (o_rd_wen !== (wen && rd != 0)) begin n_err++; $display("FAIL rnd_wen[%0d] got %b exp %b", i, o_rd_wen, wen && rd != 0); end
            n_vec++; if (o_commit_pc !== pc || o_commit_inst !== inst) begin n_err++; $display("FAIL rnd_commit[%0d] got %h/%h exp %h/%h", i, o_commit_pc, o_commit_inst, pc, inst); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_vec++; if (o_instret_cnt !== exp_instret) begin n_err++; $display("FAIL rnd_instret got %0d exp %0d", o_instret_cnt, exp_instret); end
    endtask

    task automatic test_x0();
        drive(1, 64'h3000, 32'h0000_0033, 5'd0, 1, 0, 0, 0, 64'hDEAD, 0);
        tick();
        exp_instret++;
        n_vec++; if (o_rd_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen got %b exp 0", o_rd_wen); end
        n_vec++; if (o_commit_valid !== 1'b1) begin n_err++; $display("FAIL x0_commit got %b exp 1", o_commit_valid); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_vec++; if (o_instret_cnt !== exp_instret) begin n_err++; $display("FAIL x0_instret got %0d exp %0d", o_instret_cnt, exp_instret); end
    endtask

    task automatic test_hold();
        i_hold = 1'b1;
        #1;
        n_vec++; if (mem_if.o_mem_ready !== 1'b1) begin n_err++; $display("FAIL hold_empty_ready got %b exp 1", mem_if.o_mem_ready); end
        i_hold = 1'b0;
        drive(1, 64'h4000, 32'h0000_0093, 5'd7, 1, 0, 0, 0, 64'hA5A5, 0);
        tick();
        i_hold = 1'b1;
        drive(1, 64'h4004, 32'h0000_0113, 5'd8, 1, 0, 0, 0, 64'h5A5A, 0);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (mem_if.o_mem_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got %b exp 0", c, mem_if.o_mem_ready); end
            n_vec++; if (o_commit_valid !== 1'b0 || o_rd_wen !== 1'b0) begin n_err++; $display("FAIL hold_commit[%0d] got %b/%b exp 0/0", c, o_commit_valid, o_rd_wen); end
            n_vec++; if (o_rd_data !== 64'hA5A5 || o_commit_pc !== 64'h4000 || o_rd !== 5'd7) begin n_err++; $display("FAIL hold_frozen[%0d] got %h/%h exp a5a5/4000", c, o_rd_data, o_commit_pc); end
            if (c < 2) tick();
        end
        i_hold = 1'b0;
        #1;
        exp_instret++;
        n_vec++; if (o_commit_valid !== 1'b1 || o_rd_wen !== 1'b1 || o_rd_data !== 64'hA5A5) begin n_err++; $display("FAIL hold_release got %b/%b/%h exp 1/1/a5a5", o_commit_valid, o_rd_wen, o_rd_data); end
        n_vec++; if (mem_if.o_mem_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %b exp 1", mem_if.o_mem_ready); end
        tick();
        exp_instret++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (o_commit_valid !== 1'b1 || o_rd_data !== 64'h5A5A || o_rd !== 5'd8) begin n_err++; $display("FAIL hold_next got %b/%h exp 1/5a5a", o_commit_valid, o_rd_data); end
        tick();
        n_vec++; if (o_instret_cnt !== exp_instret) begin n_err++; $display("FAIL hold_instret got %0d exp %0d", o_instret_cnt, exp_instret); end
    endtask

    task automatic test_trap();
        drive(1, 64'h5000, TRAP, 5'd5, 1, 0, 0, 0, 64'h77, 0);
        tick();
        exp_instret++;
        drive(1, 64'h5004, 32'h0000_0193, 5'd6, 1, 0, 0, 0, 64'h99, 0);
        n_vec++; if (o_commit_valid !== 1'b1 || o_rd_wen !== 1'b1 || o_commit_inst !== TRAP) begin n_err++; $display("FAIL trap_commit got %b/%b/%h exp 1/1/%h", o_commit_valid, o_rd_wen, o_commit_inst, TRAP); end
        n_vec++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL trap_halt_early got %b exp 0", o_halt); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (o_halt !== 1'b1) begin n_err++; $display("FAIL trap_halt[%0d] got %b exp 1", c, o_halt); end
            n_vec++; if (mem_if.o_mem_ready !== 1'b0) begin n_err++; $display("FAIL trap_ready[%0d] got %b exp 0", c, mem_if.o_mem_ready); end
            n_vec++; if (o_commit_valid !== 1'b0) begin n_err++; $display("FAIL trap_after_commit[%0d] got %b exp 0", c, o_commit_valid); end
            n_vec++; if (o_instret_cnt !== exp_instret) begin n_err++; $display("FAIL trap_instret[%0d] got %0d exp %0d", c, o_instret_cnt, exp_instret); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 64'd0;
        drive(1, 64'h6000, 32'h0000_0213, 5'd9, 1, 0, 0, 0, 64'hBEEF, 0);
        tick();
        i_hold = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_vec++; if (o_cycle_cnt !== tb_edges || tb_edges == 64'd0) begin n_err++; $display("FAIL ar_cycle_pre got %0d exp %0d", o_cycle_cnt, tb_edges); end
        n_vec++; if (o_commit_pc !== 64'h6000) begin n_err++; $display("FAIL ar_held got %h exp 6000", o_commit_pc); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (o_rd_data !== 64'd0 || o_commit_pc !== 64'd0 || o_commit_inst !== 32'd0 || o_rd !== 5'd0) begin n_err++; $display("FAIL ar_payload got %h/%h/%h/%0d exp 0", o_rd_data, o_commit_pc, o_commit_inst, o_rd); end
        n_vec++; if (o_cycle_cnt !== 64'd0 || o_instret_cnt !== 64'd0 || o_halt !== 1'b0) begin n_err++; $display("FAIL ar_state got %0d/%0d/%b exp 0/0/0", o_cycle_cnt, o_instret_cnt, o_halt); end
        i_hold = 1'b0;
        #1;
        n_vec++; if (o_commit_valid !== 1'b0 || o_rd_wen !== 1'b0) begin n_err++; $display("FAIL ar_commit got %b/%b exp 0/0", o_commit_valid, o_rd_wen); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_vec++; if (o_commit_valid !== 1'b0 || mem_if.o_mem_ready !== 1'b1) begin n_err++; $display("FAIL ar_after got %b/%b exp 0/1", o_commit_valid, mem_if.o_mem_ready); end
        n_vec++; if (o_cycle_cnt !== 64'd1 || o_instret_cnt !== 64'd0) begin n_err++; $display("FAIL ar_counters got %0d/%0d exp 1/0", o_cycle_cnt, o_instret_cnt); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_instret = 64'd0;
        test_reset();
        test_back_to_back();
        test_load_extract();
        test_random();
        test_x0();
        test_hold();
        test_trap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
